// File: rtl/mod_reduce_pkg.sv
// Shared constants and state encoding for the modular-reduction stage.
// Build option: MOD_REDUCE_SUB_TWICE_EN adds a second subtraction pass (SUB2).
package mod_reduce_pkg;

    localparam int X_WIDTH = 515;                        // adder result width
    localparam int M_WIDTH = 512;                        // modulus width
    localparam int LIMB    = 128;                        // bits per cycle
    localparam int NLIMB   = (X_WIDTH + LIMB - 1) / LIMB; // 5 limbs
    localparam int TOPW    = X_WIDTH - (NLIMB - 1) * LIMB; // 3-bit top limb

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        SUB2 = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mod_reduce_stage_if.sv
// Operand/result handshake bundle between the adder, this stage and its consumer.
interface mod_reduce_stage_if #(
    parameter int WIDTH     = 515,
    parameter int MOD_WIDTH = 512
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_x;
    logic [MOD_WIDTH-1:0] in_m;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-2:0]     out_r;
    logic                 out_ovf;

    // Upstream/downstream side: supplies operands, consumes results.
    modport master (
        output in_valid, in_x, in_m, out_ready,
        input  in_ready, out_valid, out_r, out_ovf
    );

    // Reduction stage side.
    modport slave (
        input  in_valid, in_x, in_m, out_ready,
        output in_ready, out_valid, out_r, out_ovf
    );
endinterface

// File: rtl/mod_reduce_stage_limb_sub.sv
// One limb of the serial subtractor: s = a + ~b + cin, carry-out = no borrow.
module limb_sub #(
    parameter int W = 128
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/mod_reduce_stage.sv
// Final conditional-subtraction stage: r = x mod M for x < 2M, computed
// limb-serially in constant time. Build option MOD_REDUCE_SUB_TWICE_EN runs a
// second pass (state SUB2) so that x < 3M is also reduced.
module mod_reduce_stage
    import mod_reduce_pkg::*;
#(
    parameter int WIDTH     = mod_reduce_pkg::X_WIDTH,
    parameter int MOD_WIDTH = mod_reduce_pkg::M_WIDTH,
    parameter int LIMB      = mod_reduce_pkg::LIMB
) (
    input  logic clk,
    input  logic resetn,
    mod_reduce_stage_if.slave bus
);
    localparam int NUM_LIMBS = (WIDTH + LIMB - 1) / LIMB;
    localparam int TOP_BITS  = WIDTH - (NUM_LIMBS - 1) * LIMB;
    localparam int DIFF_W    = NUM_LIMBS * LIMB;
    localparam int KW        = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
    // Forcing the unused upper bits of b to ones makes ~b zero there, so the
    // top-limb carry lands at bit TOP_BITS of the sum.
    localparam logic [LIMB-1:0] TOP_PAD =
        ~((LIMB'(1) << TOP_BITS) - LIMB'(1));

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   x_hold, x_work, m_work;
    logic [DIFF_W-1:0]  diff, diff_nxt;
    logic               c;
    logic [KW-1:0]      k;
    logic               out_valid_q;
    logic [WIDTH-2:0]   out_r_q;
    logic               out_ovf_q;
`ifdef MOD_REDUCE_SUB_TWICE_EN
    logic [MOD_WIDTH-1:0] m_hold;
    logic [WIDTH-1:0]     sel_pass;
`endif

    logic               accept, busy, last;
    logic [LIMB-1:0]    op_a, op_b, op_s;
    logic               op_cout, carry;
    logic [WIDTH-1:0]   sel_done;

    limb_sub #(.W(LIMB)) u_limb_sub (
        .a    (op_a),
        .b    (op_b),
        .cin  (c),
        .s    (op_s),
        .cout (op_cout)
    );

    // Limb operands, carry selection and the result mux.
    always_comb begin
        accept   = bus.in_valid && (state == IDLE);
        busy     = (state == SUB) || (state == SUB2);
        last     = (k == KW'(NUM_LIMBS - 1));
        op_a     = x_work[LIMB-1:0];
        op_b     = last ? (m_work[LIMB-1:0] | TOP_PAD) : m_work[LIMB-1:0];
        carry    = (last && (TOP_BITS < LIMB)) ? op_s[TOP_BITS % LIMB] : op_cout;
        diff_nxt = {op_s, diff[DIFF_W-1:LIMB]};
        sel_done = c ? diff[WIDTH-1:0] : x_hold;
`ifdef MOD_REDUCE_SUB_TWICE_EN
        sel_pass = carry ? diff_nxt[WIDTH-1:0] : x_hold;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; pass length is fixed, never data dependent.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = SUB;
`ifdef MOD_REDUCE_SUB_TWICE_EN
            SUB:  if (last) state_nxt = SUB2;
            SUB2: if (last) state_nxt = DONE;
`else
            SUB:  if (last) state_nxt = DONE;
            SUB2: state_nxt = IDLE;
`endif
            DONE: if (out_valid_q && bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        bus.in_ready  = resetn && (state == IDLE);
        bus.out_valid = out_valid_q;
        bus.out_r     = out_r_q;
        bus.out_ovf   = out_ovf_q;
    end

    // Working registers: operand capture and one limb per SUB/SUB2 cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_hold <= '0;
            x_work <= '0;
            m_work <= '0;
            diff   <= '0;
            c      <= 1'b0;
            k      <= '0;
`ifdef MOD_REDUCE_SUB_TWICE_EN
            m_hold <= '0;
`endif
        end else if (accept) begin
            x_hold <= bus.in_x;
            x_work <= bus.in_x;
            m_work <= WIDTH'(bus.in_m);
            c      <= 1'b1;
            k      <= '0;
`ifdef MOD_REDUCE_SUB_TWICE_EN
            m_hold <= bus.in_m;
`endif
        end else if (busy) begin
            diff   <= diff_nxt;
            c      <= carry;
            x_work <= x_work >> LIMB;
            m_work <= m_work >> LIMB;
            k      <= last ? '0 : k + KW'(1);
`ifdef MOD_REDUCE_SUB_TWICE_EN
            // End of first pass: the selected value becomes the next minuend.
            if ((state == SUB) && last) begin
                x_hold <= sel_pass;
                x_work <= sel_pass;
                m_work <= WIDTH'(m_hold);
                c      <= 1'b1;
            end
`endif
        end
    end

    // Result register: loaded once in DONE, held until the consumer takes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_ovf_q   <= 1'b0;
        end else if (state == DONE) begin
            if (!out_valid_q) begin
                out_valid_q <= 1'b1;
                out_r_q     <= sel_done[WIDTH-2:0];
                out_ovf_q   <= sel_done[WIDTH-1];
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_reduce_stage.sv
// Directed bench for mod_reduce_stage; expectations follow MOD_REDUCE_SUB_TWICE_EN.
module tb_mod_reduce_stage;
    localparam int W  = 515;
    localparam int MW = 512;
`ifdef MOD_REDUCE_SUB_TWICE_EN
    localparam bit TWICE = 1'b1;
    localparam int LAT   = 11;
`else
    localparam bit TWICE = 1'b0;
    localparam int LAT   = 6;
`endif

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mod_reduce_stage_if #(.WIDTH(W), .MOD_WIDTH(MW)) bus ();

    mod_reduce_stage #(.WIDTH(W), .MOD_WIDTH(MW), .LIMB(128)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present an operand, wait for acceptance, then count cycles to out_valid.
    task automatic start_op(input string tag, input logic [W-1:0] x, input logic [MW-1:0] m);
        int guard;
        @(negedge clk);
        bus.in_x     = x;
        bus.in_m     = m;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [MW-1:0] m,
                          input logic [W-1:0] exp_r, input logic exp_ovf);
        int lat;
        start_op(tag, x, m);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check_eq({tag, "_lat"}, W'(lat), W'(LAT));
        check_eq({tag, "_r"}, W'(bus.out_r), exp_r);
        check_eq({tag, "_ovf"}, W'(bus.out_ovf), W'(exp_ovf));
    endtask

    task automatic complete_out(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check_eq({tag, "_rdy_after"}, W'(bus.in_ready), W'(1));
        check_eq({tag, "_vld_after"}, W'(bus.out_valid), W'(0));
    endtask

    initial begin
        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_m      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", W'(bus.out_valid), W'(0));
        check_eq("rst_out_r", W'(bus.out_r), W'(0));
        check_eq("rst_out_ovf", W'(bus.out_ovf), W'(0));
        check_eq("rst_in_ready", W'(bus.in_ready), W'(0));
        @(negedge clk) resetn = 1'b1;
        #1 check_eq("idle_in_ready", W'(bus.in_ready), W'(1));

        // x < M passes through; then backpressure with an ignored new operand.
        run_op("x5_m7", W'(5), MW'(7), W'(5), 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_x     = W'(12345);
            bus.in_m     = MW'(7);
            @(posedge clk);
            #1;
            check_eq("bp_valid", W'(bus.out_valid), W'(1));
            check_eq("bp_r", W'(bus.out_r), W'(5));
            check_eq("bp_in_ready", W'(bus.in_ready), W'(0));
        end
        @(negedge clk) bus.in_valid = 1'b0;
        complete_out("bp");
        repeat (8) @(posedge clk);
        #1 check_eq("bp_no_stale_op", W'(bus.out_valid), W'(0));

        run_op("x_eq_m", W'(7), MW'(7), W'(0), 1'b0);
        complete_out("x_eq_m");
        run_op("x_2m_m1", (W'(1) << 512) + W'(1), (MW'(1) << 511) + MW'(1), W'(1) << 511, 1'b0);
        complete_out("x_2m_m1");
        run_op("borrow128", W'(1) << 128, MW'(1),
               TWICE ? (W'(1) << 128) - W'(2) : (W'(1) << 128) - W'(1), 1'b0);
        complete_out("borrow128");
        run_op("borrow384", W'(1) << 384, (MW'(1) << 384) - MW'(1), W'(1), 1'b0);
        complete_out("borrow384");
        run_op("x_2m_p3", W'(2003), MW'(1000), TWICE ? W'(3) : W'(1003), 1'b0);
        complete_out("x_2m_p3");
        run_op("ovf_top", (W'(1) << 514) + W'(5), MW'(3),
               TWICE ? (W'(1) << 514) - W'(1) : W'(2), TWICE ? 1'b0 : 1'b1);
        complete_out("ovf_top");

        // Reset during SUB: the operation must be abandoned.
        start_op("rst_sub", W'(2003), MW'(1000));
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check_eq("rst_sub_valid", W'(bus.out_valid), W'(0));
        check_eq("rst_sub_in_ready", W'(bus.in_ready), W'(0));
        @(negedge clk) resetn = 1'b1;
        repeat (12) @(posedge clk);
        #1 check_eq("rst_sub_no_result", W'(bus.out_valid), W'(0));

        // Reset during DONE: the held result must vanish at once.
        run_op("pre_rst_done", W'(2003), MW'(1000), TWICE ? W'(3) : W'(1003), 1'b0);
        #2 resetn = 1'b0;
        #1;
        check_eq("rst_done_valid", W'(bus.out_valid), W'(0));
        check_eq("rst_done_r", W'(bus.out_r), W'(0));
        @(negedge clk) resetn = 1'b1;

        run_op("x9_m4", W'(9), MW'(4), TWICE ? W'(1) : W'(5), 1'b0);
        complete_out("x9_m4");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
